lt24_frame_sequencer: RTL

//  Schedules full-frame pixel transfers into lt24_lcd_driver after its init completes.

---
 rtl/lt24_frame_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/lt24_frame_sequencer.sv
// Frame sequencer for lt24_lcd_driver: streams a framebuffer or paints a fill
// colour as whole frames, two en cycles per pixel.
module lt24_frame_sequencer #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              initialized,
  input  logic              frame_req,
  input  logic              fill_req,
  input  logic [15:0]       fill_color,
  input  logic [15:0]       fb_rdata,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  output logic [15:0]       pixel_rgb,
  output logic              print,
  output logic              busy,
  output logic              frame_done
);

  localparam int N = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE, RD0, WAIT0, SEND_A, SEND_B, DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nx;
  logic              pend_s;
  logic              pend_f;
  logic              is_fill;
  logic [15:0]       col_reg;
  logic [15:0]       pix_src;
  logic              more;
  logic              start;
  logic              start_f;
  logic              abort;

  assign cnt_nx  = cnt + ONE;
  assign more    = (cnt != LAST);
  assign pix_src = is_fill ? col_reg : fb_rdata;
  assign start   = (state == IDLE) && initialized
                 && (pend_f || pend_s);
  assign start_f = start && pend_f;
  assign abort   = !initialized && (state != IDLE)
                 && (state != DONE);

  // Read one pixel ahead so the RAM data lands in the SEND_B cycle.
  assign fb_rd = en && !is_fill
               && ((state == RD0) || ((state == SEND_A) && more));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_s     <= 1'b0;
      pend_f     <= 1'b0;
      is_fill    <= 1'b0;
      col_reg    <= '0;
      fb_addr    <= '0;
      pixel_rgb  <= '0;
      print      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else if (en) begin
      pend_s <= (pend_s && !(start && !pend_f)) || frame_req;
      pend_f <= (pend_f && !start_f) || fill_req;
      if (fill_req) col_reg <= fill_color;
      if (abort) begin
        state <= IDLE;
        print <= 1'b0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state   <= RD0;
              busy    <= 1'b1;
              is_fill <= pend_f;
              fb_addr <= '0;
            end
          end
          RD0: state <= WAIT0;
          WAIT0: begin
            state     <= SEND_A;
            pixel_rgb <= pix_src;
            cnt       <= '0;
            print     <= 1'b1;
            if (LAST != '0) fb_addr <= ONE;
          end
          SEND_A: state <= SEND_B;
          SEND_B: begin
            if (more) begin
              state     <= SEND_A;
              pixel_rgb <= pix_src;
              cnt       <= cnt_nx;
              if (cnt_nx != LAST) fb_addr <= cnt_nx + ONE;
            end else begin
              state      <= DONE;
              print      <= 1'b0;
              frame_done <= 1'b1;
            end
          end
          DONE: begin
            state      <= IDLE;
            frame_done <= 1'b0;
            busy       <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
